// File: rtl/fifo_arb_pkg.sv
// Shared types and the round-robin search used by the async-FIFO write-port arbiter.
package fifo_arb_pkg;

  localparam int unsigned STATS_W = 16;
  localparam int unsigned MAX_REQ = 16;
  localparam int unsigned MAX_IW  = 4;

  typedef enum logic {IDLE, LOCK} arb_state_e;

  // First set bit of valid at or after ptr, wrapping modulo nreq; returns ptr when none set.
  function automatic logic [MAX_IW-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                input logic [MAX_IW-1:0]  ptr,
                                                input int unsigned        nreq);
    logic [MAX_IW-1:0] idx;
    logic              found;
    int unsigned       j;
    idx   = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      j = 32'(ptr) + k;
      if (j >= nreq) j = j - nreq;
      if ((k < nreq) && !found && valid[MAX_IW'(j)]) begin
        idx   = MAX_IW'(j);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick_arb.sv
// Combinational round-robin priority search: lowest valid index at or after ptr.
module rr_pick_arb
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   idx,
  output logic            any
);

  always_comb begin
    idx = IW'(rr_pick(MAX_REQ'(valid), MAX_IW'(ptr), NREQ));
    any = |valid;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-atomic round-robin arbiter sharing one async-FIFO write port among NREQ requesters.
// Define FIFO_WR_ARB_STATS_EN to add per-requester beat counters and a wfull stall counter.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  parameter  int unsigned DW   = 32,
  localparam int unsigned IW   = $clog2(NREQ)
) (
  input  logic               wclk,
  input  logic               wrst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]    req_last,
  output logic [NREQ-1:0]    req_ready,
  input  logic               wfull,
  output logic               push,
  output logic [DW-1:0]      wdata,
  output logic [IW-1:0]      gnt_id,
  output logic               busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NREQ*STATS_W-1:0] beat_cnt,
  output logic [STATS_W-1:0]      stall_cnt
`endif
);

  arb_state_e    state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic          owner_valid;
  logic          owner_last;

  rr_pick_arb #(.NREQ(NREQ), .IW(IW)) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Write-side handshake is combinational off the registered owner so a beat moves the cycle wfull drops.
  always_comb begin
    req_ready   = '0;
    push        = 1'b0;
    owner_valid = req_valid[gnt_id];
    owner_last  = req_last[gnt_id];
    wdata       = req_data[gnt_id*DW +: DW];
    if (state == LOCK) begin
      req_ready[gnt_id] = !wfull;
      push              = owner_valid && !wfull;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      gnt_id <= '0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            gnt_id <= pick_idx;
            busy   <= 1'b1;
            state  <= LOCK;
          end
        end
        LOCK: begin
          if (push && owner_last) begin
            state  <= IDLE;
            busy   <= 1'b0;
            rr_ptr <= (gnt_id == IW'(NREQ-1)) ? '0 : gnt_id + IW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  // Beat counters wrap; the stall counter saturates so long stalls stay visible.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      beat_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (push)
        beat_cnt[gnt_id*STATS_W +: STATS_W] <= beat_cnt[gnt_id*STATS_W +: STATS_W] + STATS_W'(1);
      if ((state == LOCK) && owner_valid && wfull && (stall_cnt != '1))
        stall_cnt <= stall_cnt + STATS_W'(1);
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: vector tables plus multi-cycle corner sequences.
module tb_fifo_wr_arbiter;

  logic         wclk = 1'b0;
  logic         wrst_n;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_last;
  logic [3:0]   req_ready;
  logic         wfull;
  logic         push;
  logic [31:0]  wdata;
  logic [1:0]   gnt_id;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] last;
    logic       wfull;
    logic [7:0] beat;
    logic       e_push;
    logic [3:0] e_ready;
    logic       e_busy;
    logic [1:0] e_gnt;
  } vec_t;

  fifo_wr_arbiter #(.NREQ(4), .DW(32)) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .wfull     (wfull),
    .push      (push),
    .wdata     (wdata),
    .gnt_id    (gnt_id),
    .busy      (busy)
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input int g, input logic [7:0] beat);
    return 32'hA000_0000 | (32'(g) << 8) | 32'(beat);
  endfunction

  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic f, input logic [7:0] beat);
    req_valid = v;
    req_last  = l;
    wfull     = f;
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = exp_data(i, beat);
  endtask

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic f,
                              input logic [7:0] beat, input logic ep, input logic [3:0] er,
                              input logic eb, input logic [1:0] eg);
    vec_t r;
    r.valid = v;  r.last = l;  r.wfull = f;  r.beat = beat;
    r.e_push = ep; r.e_ready = er; r.e_busy = eb; r.e_gnt = eg;
    return r;
  endfunction

  task automatic run_vecs(input vec_t vs[$], input string tag);
    foreach (vs[i]) begin
      @(negedge wclk);
      drive(vs[i].valid, vs[i].last, vs[i].wfull, vs[i].beat);
      #1;
      chk($sformatf("%s[%0d].push", tag, i), 32'(push), 32'(vs[i].e_push));
      chk($sformatf("%s[%0d].ready", tag, i), 32'(req_ready), 32'(vs[i].e_ready));
      chk($sformatf("%s[%0d].busy", tag, i), 32'(busy), 32'(vs[i].e_busy));
      if (vs[i].e_busy) chk($sformatf("%s[%0d].gnt", tag, i), 32'(gnt_id), 32'(vs[i].e_gnt));
      if (vs[i].e_push)
        chk($sformatf("%s[%0d].wdata", tag, i), wdata, exp_data(int'(vs[i].e_gnt), vs[i].beat));
    end
  endtask

  task automatic apply_reset(input string tag);
    @(negedge wclk);
    wrst_n = 1'b0;
    drive(4'b1111, 4'b1111, 1'b0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      @(negedge wclk);
      #1;
      chk($sformatf("%s.push", tag), 32'(push), 32'd0);
      chk($sformatf("%s.ready", tag), 32'(req_ready), 32'd0);
      chk($sformatf("%s.busy", tag), 32'(busy), 32'd0);
      chk($sformatf("%s.gnt", tag), 32'(gnt_id), 32'd0);
    end
    @(negedge wclk);
    drive(4'b0000, 4'b0000, 1'b0, 8'h00);
    wrst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t1[$];
    vec_t t2[$];
    int   order[5];
    int   idx;
    bit   done;
    logic f;

    wrst_n = 1'b0;
    drive(4'b1111, 4'b1111, 1'b0, 8'h00);
    apply_reset("rst0");

    // Single requester 3-beat packet, then a full round starting at rr_ptr=2, then wfull gaps.
    t1.push_back(mk(4'b0010, 4'b0000, 1'b0, 8'h01, 1'b0, 4'b0000, 1'b0, 2'd0));
    t1.push_back(mk(4'b0010, 4'b0000, 1'b0, 8'h01, 1'b1, 4'b0010, 1'b1, 2'd1));
    t1.push_back(mk(4'b0010, 4'b0000, 1'b0, 8'h02, 1'b1, 4'b0010, 1'b1, 2'd1));
    t1.push_back(mk(4'b0010, 4'b0010, 1'b0, 8'h03, 1'b1, 4'b0010, 1'b1, 2'd1));
    t1.push_back(mk(4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b0, 2'd0));
    t1.push_back(mk(4'b1111, 4'b1111, 1'b0, 8'h04, 1'b0, 4'b0000, 1'b0, 2'd0));
    t1.push_back(mk(4'b1111, 4'b1111, 1'b0, 8'h04, 1'b1, 4'b0100, 1'b1, 2'd2));
    t1.push_back(mk(4'b1111, 4'b1111, 1'b0, 8'h04, 1'b0, 4'b0000, 1'b0, 2'd0));
    t1.push_back(mk(4'b1111, 4'b1111, 1'b0, 8'h04, 1'b1, 4'b1000, 1'b1, 2'd3));
    t1.push_back(mk(4'b1111, 4'b1111, 1'b0, 8'h04, 1'b0, 4'b0000, 1'b0, 2'd0));
    t1.push_back(mk(4'b1111, 4'b1111, 1'b0, 8'h04, 1'b1, 4'b0001, 1'b1, 2'd0));
    t1.push_back(mk(4'b0010, 4'b0000, 1'b1, 8'h05, 1'b0, 4'b0000, 1'b0, 2'd0));
    t1.push_back(mk(4'b0010, 4'b0000, 1'b1, 8'h05, 1'b0, 4'b0000, 1'b1, 2'd1));
    t1.push_back(mk(4'b0010, 4'b0000, 1'b0, 8'h05, 1'b1, 4'b0010, 1'b1, 2'd1));
    t1.push_back(mk(4'b0010, 4'b0010, 1'b1, 8'h06, 1'b0, 4'b0000, 1'b1, 2'd1));
    t1.push_back(mk(4'b0010, 4'b0010, 1'b0, 8'h06, 1'b1, 4'b0010, 1'b1, 2'd1));
    t1.push_back(mk(4'b0001, 4'b0001, 1'b0, 8'h07, 1'b0, 4'b0000, 1'b0, 2'd0));
    t1.push_back(mk(4'b0011, 4'b0001, 1'b0, 8'h07, 1'b1, 4'b0001, 1'b1, 2'd0));
    t1.push_back(mk(4'b0010, 4'b0010, 1'b0, 8'h08, 1'b0, 4'b0000, 1'b0, 2'd0));
    t1.push_back(mk(4'b0010, 4'b0010, 1'b0, 8'h08, 1'b1, 4'b0010, 1'b1, 2'd1));
    run_vecs(t1, "tbl");

    // After reset all four request single-beat packets: grants 0,1,2,3,0, one push every 2 cycles.
    apply_reset("rst1");
    order = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 10; k++) begin
      @(negedge wclk);
      drive(4'b1111, 4'b1111, 1'b0, 8'h30);
      #1;
      chk($sformatf("rr[%0d].push", k), 32'(push), 32'(k % 2));
      if ((k % 2) == 1) begin
        chk($sformatf("rr[%0d].gnt", k), 32'(gnt_id), 32'(order[k/2]));
        chk($sformatf("rr[%0d].wdata", k), wdata, exp_data(order[k/2], 8'h30));
      end
    end

    // Requester 3, 4-beat packet with wfull high for 5 cycles mid-packet.
    idx  = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 30 && !done; cyc++) begin
      @(negedge wclk);
      f = (cyc >= 2) && (cyc < 7);
      drive((idx < 4) ? 4'b1000 : 4'b0000, (idx == 3) ? 4'b1000 : 4'b0000, f, 8'(idx));
      #1;
      if (f) begin
        chk($sformatf("full[%0d].push", cyc), 32'(push), 32'd0);
        chk($sformatf("full[%0d].ready", cyc), 32'(req_ready), 32'd0);
        chk($sformatf("full[%0d].busy", cyc), 32'(busy), 32'd1);
      end
      if (busy) chk($sformatf("full[%0d].gnt", cyc), 32'(gnt_id), 32'd3);
      if (push) begin
        chk($sformatf("full[%0d].wdata", cyc), wdata, exp_data(3, 8'(idx)));
        idx++;
      end
      if ((idx == 4) && !busy) done = 1'b1;
    end
    chk("full.beats", 32'(idx), 32'd4);
    chk("full.done", 32'(done), 32'd1);

    // Owner 2 drops valid for 3 cycles while requester 0 waits; grant is held to its last beat.
    t2.push_back(mk(4'b0100, 4'b0000, 1'b0, 8'h10, 1'b0, 4'b0000, 1'b0, 2'd0));
    t2.push_back(mk(4'b0101, 4'b0000, 1'b0, 8'h11, 1'b1, 4'b0100, 1'b1, 2'd2));
    t2.push_back(mk(4'b0001, 4'b0000, 1'b0, 8'h11, 1'b0, 4'b0100, 1'b1, 2'd2));
    t2.push_back(mk(4'b0001, 4'b0000, 1'b0, 8'h11, 1'b0, 4'b0100, 1'b1, 2'd2));
    t2.push_back(mk(4'b0001, 4'b0000, 1'b0, 8'h11, 1'b0, 4'b0100, 1'b1, 2'd2));
    t2.push_back(mk(4'b0101, 4'b0000, 1'b0, 8'h12, 1'b1, 4'b0100, 1'b1, 2'd2));
    t2.push_back(mk(4'b0101, 4'b0100, 1'b0, 8'h13, 1'b1, 4'b0100, 1'b1, 2'd2));
    t2.push_back(mk(4'b0001, 4'b0001, 1'b0, 8'h14, 1'b0, 4'b0000, 1'b0, 2'd0));
    t2.push_back(mk(4'b0001, 4'b0001, 1'b0, 8'h14, 1'b1, 4'b0001, 1'b1, 2'd0));
    run_vecs(t2, "drop");

    // Reset mid-packet: outputs drop at once, arbitration restarts from index 0.
    @(negedge wclk);
    drive(4'b0010, 4'b0000, 1'b0, 8'h20);
    #1;
    chk("mrst.idle_busy", 32'(busy), 32'd0);
    @(negedge wclk);
    #1;
    chk("mrst.pre_push", 32'(push), 32'd1);
    chk("mrst.pre_gnt", 32'(gnt_id), 32'd1);
    #1;
    wrst_n = 1'b0;
    #1;
    chk("mrst.busy", 32'(busy), 32'd0);
    chk("mrst.push", 32'(push), 32'd0);
    chk("mrst.ready", 32'(req_ready), 32'd0);
    chk("mrst.gnt", 32'(gnt_id), 32'd0);
    @(negedge wclk);
    drive(4'b1111, 4'b1111, 1'b0, 8'h21);
    #1;
    chk("mrst.hold_busy", 32'(busy), 32'd0);
    @(negedge wclk);
    wrst_n = 1'b1;
    #1;
    chk("mrst.rel_busy", 32'(busy), 32'd0);
    @(negedge wclk);
    #1;
    chk("mrst.first_busy", 32'(busy), 32'd1);
    chk("mrst.first_gnt", 32'(gnt_id), 32'd0);
    chk("mrst.first_push", 32'(push), 32'd1);
    chk("mrst.first_wdata", wdata, exp_data(0, 8'h21));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
